// File: rtl/s_stream_feeder_pkg.sv
// Shared types and defaults for the streaming operand feeder.
// The feeder FSM encoding and the PEA operand width live here.
package s_stream_feeder_pkg;

  localparam int PEA_N_BITS = 16;

  typedef enum logic [1:0] {
    F_IDLE   = 2'd0,
    F_STREAM = 2'd1,
    F_DONE   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/s_stream_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a synchronous clear.
// A push while full and a pop while empty are ignored.
module s_stream_fifo
  import s_stream_feeder_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_next;

  assign w_push  = push_i && !r_full;
  assign w_pop   = pop_i && !r_empty;
  assign data_o  = r_mem[r_rd_ptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;

  // Occupancy after this cycle's push/pop, used to register the flags.
  always_comb begin
    w_cnt_next = r_count;
    if (w_push && !w_pop) begin
      w_cnt_next = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_cnt_next = r_count - CNT_ONE;
    end else begin
      w_cnt_next = r_count;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_cnt_next;
      r_full  <= (w_cnt_next == CNT_FULL);
      r_empty <= (w_cnt_next == {CW{1'b0}});
    end
  end

  // Storage needs no reset: flags guard every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/s_stream_feeder.sv
// Drives one PEA edge operand (data + valid) from a memory-side valid/ready stream,
// counting a configured transfer length and pulsing done when the last word is consumed.
module s_stream_feeder
  import s_stream_feeder_pkg::*;
#(
  parameter int N_BITS     = PEA_N_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              flush_i,
  input  logic [N_BITS-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              pea_ready_i,
  output logic              valid_o,
  output logic [N_BITS-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  feeder_state_t     r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_acc_cnt;
  logic [LEN_W-1:0]  r_cons_cnt;
  logic              r_valid;
  logic [N_BITS-1:0] r_data;
  logic              r_busy;
  logic              r_done;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [N_BITS-1:0] w_fifo_data;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_load;
  logic              w_consume;
  logic              w_last;

  // Ready is built from the registered full flag, so a same-cycle pop never opens a slot early.
  assign w_in_ready = (r_state == F_STREAM) && !w_fifo_full && (r_acc_cnt < r_len);
  assign w_accept   = in_valid_i && w_in_ready;
  assign w_load     = (!r_valid || pea_ready_i) && !w_fifo_empty;
  assign w_consume  = r_valid && pea_ready_i;
  assign w_last     = (r_cons_cnt == (r_len - LEN_ONE));

  assign in_ready_o = w_in_ready;
  assign valid_o    = r_valid;
  assign data_o     = r_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

  s_stream_fifo #(
    .W     (N_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (w_accept),
    .pop_i   (w_load),
    .data_i  (in_data_i),
    .data_o  (w_fifo_data),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Transfer FSM with its counters and the busy/done flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= F_IDLE;
      r_len      <= {LEN_W{1'b0}};
      r_acc_cnt  <= {LEN_W{1'b0}};
      r_cons_cnt <= {LEN_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (flush_i) begin
      r_state    <= F_IDLE;
      r_acc_cnt  <= {LEN_W{1'b0}};
      r_cons_cnt <= {LEN_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        F_IDLE: begin
          if (start_i) begin
            r_len      <= len_i;
            r_acc_cnt  <= {LEN_W{1'b0}};
            r_cons_cnt <= {LEN_W{1'b0}};
            r_busy     <= 1'b1;
            if (len_i == {LEN_W{1'b0}}) begin
              r_state <= F_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= F_STREAM;
              r_done  <= 1'b0;
            end
          end else begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
          end
        end
        F_STREAM: begin
          if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + LEN_ONE;
          end
          if (w_consume) begin
            r_cons_cnt <= r_cons_cnt + LEN_ONE;
            if (w_last) begin
              r_state <= F_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        F_DONE: begin
          r_state <= F_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= F_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Operand register: refill from the FIFO whenever the current word is gone or being taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= {N_BITS{1'b0}};
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_fifo_data;
    end else if (!r_valid || pea_ready_i) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule
